// File: rtl/nn_rnn_weight_update_polar.sv
// Windowed delta*activation accumulator with a shifted gradient-descent step on a stored
// signed weight, which is re-emitted as a polar stochastic stream (magnitude bit + sign).
module nn_rnn_weight_update_polar #(
    parameter int WEIGHT_W = 8,
    parameter int WIN_LOG2 = 8,
    parameter int LR_SHIFT = 4,
    parameter int W_INIT   = 0
) (
    input  logic                       CLK,
    input  logic                       INIT,
    input  logic                       START,
    input  logic                       EN,
    input  logic                       TRAIN,
    input  logic                       delta,
    input  logic                       SIGN_delta,
    input  logic                       act,
    input  logic [WEIGHT_W-2:0]        RAND,
    input  logic                       W_LOAD,
    input  logic signed [WEIGHT_W-1:0] W_LOAD_VAL,
    output logic signed [WEIGHT_W-1:0] W,
    output logic                       W_STREAM,
    output logic                       SIGN_W,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int AW    = WIN_LOG2 + 2;
    localparam int SW    = WEIGHT_W + WIN_LOG2 + 2;
    localparam int W_MAX = 2 ** (WEIGHT_W - 1) - 1;
    localparam int W_INIT_SAT = (W_INIT > W_MAX) ? W_MAX : ((W_INIT < -W_MAX) ? -W_MAX : W_INIT);
    localparam logic signed [WEIGHT_W-1:0] W_RST   = WEIGHT_W'(W_INIT_SAT);
    localparam logic signed [SW-1:0]       SAT_HI  = SW'(W_MAX);
    localparam logic signed [SW-1:0]       SAT_LO  = -SAT_HI;
    localparam logic signed [AW-1:0]       ACC_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

    state_t                       state_q, state_d;
    logic signed [AW-1:0]         acc_q, acc_d;
    logic [WIN_LOG2-1:0]          win_cnt_q, win_cnt_d;
    logic signed [WEIGHT_W-1:0]   w_q, w_d;
    logic                         w_stream_q, w_stream_d;
    logic                         sign_w_q, sign_w_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    logic signed [AW-1:0]         step;
    logic signed [SW-1:0]         w_ext, step_ext, load_ext;
    logic [WEIGHT_W-1:0]          w_mag;

    // Symmetric clamp: the most negative code is never stored, so |W| always fits WEIGHT_W-1 bits.
    function automatic logic signed [WEIGHT_W-1:0] sat_w(input logic signed [SW-1:0] x);
        if (x > SAT_HI) return SAT_HI[WEIGHT_W-1:0];
        if (x < SAT_LO) return SAT_LO[WEIGHT_W-1:0];
        return x[WEIGHT_W-1:0];
    endfunction

    assign step     = acc_q >>> LR_SHIFT;
    assign w_ext    = {{(SW-WEIGHT_W){w_q[WEIGHT_W-1]}}, w_q};
    assign step_ext = {{(SW-AW){step[AW-1]}}, step};
    assign load_ext = {{(SW-WEIGHT_W){W_LOAD_VAL[WEIGHT_W-1]}}, W_LOAD_VAL};
    assign w_mag    = w_q[WEIGHT_W-1] ? WEIGHT_W'(-w_q) : w_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        win_cnt_d = win_cnt_q;
        w_d       = w_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d   = ACCUM;
                    acc_d     = '0;
                    win_cnt_d = '0;
                end
            end
            ACCUM: begin
                if (EN) begin
                    win_cnt_d = win_cnt_q + WIN_LOG2'(1);
                    if (delta && act) begin
                        acc_d = SIGN_delta ? (acc_q - ACC_ONE) : (acc_q + ACC_ONE);
                    end
                    if (&win_cnt_q) state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
                if (TRAIN) w_d = sat_w(w_ext - step_ext);
            end
            default: state_d = IDLE;
        endcase
        // An explicit load overrides any gradient step landing in the same cycle.
        if (W_LOAD) w_d = sat_w(load_ext);
        w_stream_d = (w_mag > {1'b0, RAND});
        sign_w_d   = w_q[WEIGHT_W-1];
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == UPDATE);
    end

    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            win_cnt_q  <= '0;
            w_q        <= W_RST;
            w_stream_q <= 1'b0;
            sign_w_q   <= W_RST[WEIGHT_W-1];
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            win_cnt_q  <= win_cnt_d;
            w_q        <= w_d;
            w_stream_q <= w_stream_d;
            sign_w_q   <= sign_w_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign W        = w_q;
    assign W_STREAM = w_stream_q;
    assign SIGN_W   = sign_w_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_nn_rnn_weight_update_polar.sv
// Bench for nn_rnn_weight_update_polar: table-driven weight loads, directed windows and a
// randomized run, all checked against a behavioural model kept in integer arithmetic.
module tb_nn_rnn_weight_update_polar;

    localparam int WW   = 8;
    localparam int WL   = 4;
    localparam int LR   = 2;
    localparam int WI   = 10;
    localparam int WMAX = 2 ** (WW - 1) - 1;
    localparam int WIN  = 2 ** WL;

    logic                 CLK = 1'b0;
    logic                 INIT, START, EN, TRAIN, delta, SIGN_delta, act, W_LOAD;
    logic [WW-2:0]        RAND;
    logic signed [WW-1:0] W_LOAD_VAL;
    logic signed [WW-1:0] W;
    logic                 W_STREAM, SIGN_W, BUSY, DONE;

    nn_rnn_weight_update_polar #(
        .WEIGHT_W(WW), .WIN_LOG2(WL), .LR_SHIFT(LR), .W_INIT(WI)
    ) dut (
        .CLK(CLK), .INIT(INIT), .START(START), .EN(EN), .TRAIN(TRAIN),
        .delta(delta), .SIGN_delta(SIGN_delta), .act(act), .RAND(RAND),
        .W_LOAD(W_LOAD), .W_LOAD_VAL(W_LOAD_VAL),
        .W(W), .W_STREAM(W_STREAM), .SIGN_W(SIGN_W), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: phase 0 idle, 1 accumulating, 2 update cycle.
    int m_phase, m_acc, m_cnt, m_w;
    bit m_ws, m_sw;

    function automatic int sat(input int x);
        if (x > WMAX) return WMAX;
        if (x < -WMAX) return -WMAX;
        return x;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic chk(input string nm, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, actual, required, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_acc = 0; m_cnt = 0;
        m_w = sat(WI); m_ws = 1'b0; m_sw = (sat(WI) < 0);
    endtask

    task automatic model_edge();
        int nw;
        nw = m_w;
        if (m_phase == 2 && TRAIN) nw = sat(m_w - (m_acc >>> LR));
        if (W_LOAD) nw = sat(int'(W_LOAD_VAL));
        m_ws = (iabs(m_w) > int'(RAND));
        m_sw = (m_w < 0);
        case (m_phase)
            0: if (START) begin m_phase = 1; m_acc = 0; m_cnt = 0; end
            1: if (EN) begin
                   if (delta && act) m_acc += SIGN_delta ? -1 : 1;
                   m_cnt++;
                   if (m_cnt == WIN) m_phase = 2;
               end
            default: m_phase = 0;
        endcase
        m_w = nw;
    endtask

    task automatic check_model();
        logic [11:0] a, e;
        a = {W, W_STREAM, SIGN_W, BUSY, DONE};
        e = {8'(m_w), m_ws, m_sw, (m_phase != 0), (m_phase == 2)};
        chk("cycle_outputs", int'(a), int'(e));
    endtask

    task automatic tick();
        @(posedge CLK);
        if (INIT) model_edge();
        @(negedge CLK);
        check_model();
    endtask

    task automatic load_w(input int v);
        W_LOAD = 1'b1; W_LOAD_VAL = 8'(v);
        tick();
        W_LOAD = 1'b0;
    endtask

    // Runs one window; returns the number of EN-high cycles seen before DONE.
    task automatic do_window(input bit sgn, input bit train, input bit toggle,
                             input int mid_start_at, output int n_en);
        bit done_seen;
        done_seen = 1'b0;
        n_en = 0;
        TRAIN = train; EN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0; delta = 1'b1; act = 1'b1; SIGN_delta = sgn;
        for (int k = 0; k < 100 && !done_seen; k++) begin
            EN = toggle ? (k % 2 == 0) : 1'b1;
            START = (k == mid_start_at);
            if (EN) n_en++;
            tick();
            if (DONE) done_seen = 1'b1;
        end
        START = 1'b0; EN = 1'b0;
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL window_timeout actual=no_done required=done");
        end
    endtask

    typedef struct {
        int       val;
        int       rnd;
        int       exp_w;
        bit       exp_sgn;
        bit       exp_str;
    } ld_vec_t;

    ld_vec_t tbl[8];
    int      n, ones;
    int      exp_w3[3];

    initial begin
        tbl[0] = '{-128,   0, -127, 1'b1, 1'b1};
        tbl[1] = '{ 127, 126,  127, 1'b0, 1'b1};
        tbl[2] = '{ 127, 127,  127, 1'b0, 1'b0};
        tbl[3] = '{   0,   0,    0, 1'b0, 1'b0};
        tbl[4] = '{  -5,   4,   -5, 1'b1, 1'b1};
        tbl[5] = '{  -5,   5,   -5, 1'b1, 1'b0};
        tbl[6] = '{  64,  63,   64, 1'b0, 1'b1};
        tbl[7] = '{  64,  64,   64, 1'b0, 1'b0};

        INIT = 1'b0; START = 1'b0; EN = 1'b0; TRAIN = 1'b0; delta = 1'b0;
        SIGN_delta = 1'b0; act = 1'b0; W_LOAD = 1'b0; W_LOAD_VAL = '0; RAND = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("reset_W", int'(W), 10);
        chk("reset_SIGN_W", int'(SIGN_W), 0);
        chk("reset_BUSY", int'(BUSY), 0);
        chk("reset_DONE", int'(DONE), 0);
        chk("reset_W_STREAM", int'(W_STREAM), 0);
        INIT = 1'b1;
        tick();

        // +1 contributions: acc=16, step=4 per window from W=10.
        exp_w3 = '{6, 2, -2};
        for (int i = 0; i < 3; i++) begin
            do_window(1'b0, 1'b1, 1'b0, -1, n);
            chk("plus_window_en_cycles", n, WIN);
            tick();
            chk("plus_window_W", int'(W), exp_w3[i]);
        end
        tick();
        chk("plus_window_SIGN_W", int'(SIGN_W), 1);

        // -1 contributions from 120: step=-4, then saturation at +127.
        load_w(120);
        exp_w3 = '{124, 127, 127};
        for (int i = 0; i < 3; i++) begin
            do_window(1'b1, 1'b1, 1'b0, -1, n);
            tick();
            chk("minus_window_W", int'(W), exp_w3[i]);
        end

        // Toggled EN, ignored START mid-window, TRAIN=0 holds W.
        do_window(1'b1, 1'b0, 1'b1, 5, n);
        chk("toggle_en_cycles", n, WIN);
        tick();
        chk("train0_W_held", int'(W), 127);
        chk("done_one_cycle", int'(DONE), 0);

        // Load in the update cycle overrides the gradient step.
        do_window(1'b0, 1'b1, 1'b0, -1, n);
        load_w(-50);
        chk("load_beats_update", int'(W), -50);

        for (int i = 0; i < 8; i++) begin
            load_w(tbl[i].val);
            chk("tbl_W", int'(W), tbl[i].exp_w);
            RAND = 7'(tbl[i].rnd);
            tick();
            chk("tbl_W_STREAM", int'(W_STREAM), int'(tbl[i].exp_str));
            chk("tbl_SIGN_W", int'(SIGN_W), int'(tbl[i].exp_sgn));
        end

        // Stream density at W=64 with uniform RAND.
        load_w(64);
        ones = 0;
        for (int i = 0; i < 4096; i++) begin
            RAND = 7'($urandom_range(0, 127));
            tick();
            if (W_STREAM) ones++;
        end
        checks++;
        if (ones < 1925 || ones > 2171) begin
            failures++;
            $display("FAIL stream_density actual=%0d/4096 required=1925..2171", ones);
        end
        chk("density_SIGN_W", int'(SIGN_W), 0);

        // Asynchronous INIT mid-window.
        START = 1'b1; tick(); START = 1'b0;
        EN = 1'b1; delta = 1'b1; act = 1'b1;
        repeat (5) tick();
        INIT = 1'b0;
        #1;
        model_reset();
        chk("init_mid_W", int'(W), 10);
        chk("init_mid_BUSY", int'(BUSY), 0);
        chk("init_mid_W_STREAM", int'(W_STREAM), 0);
        @(negedge CLK);
        INIT = 1'b1; EN = 1'b0;
        tick();
        chk("init_mid_idle", int'(BUSY), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            START      = ($urandom_range(0, 7) == 0);
            EN         = $urandom_range(0, 1) == 1;
            TRAIN      = ($urandom_range(0, 3) != 0);
            delta      = $urandom_range(0, 1) == 1;
            act        = ($urandom_range(0, 3) != 0);
            SIGN_delta = $urandom_range(0, 2) == 0;
            W_LOAD     = ($urandom_range(0, 63) == 0);
            W_LOAD_VAL = 8'($urandom);
            RAND       = 7'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
